imem_loader: RTL and testbench

Boot-time instruction-memory loader that sits upstream of the RISC_TOY core's instruction port. It receives a byte stream containing a header word count, N instruction words and a trailing checksum. It writes the words into instruction memory at word addresses 0..N-1 and holds the core in reset until the image is verified. After a good load it hands the instruction-memory port to the core and releases the core's reset; after a bad load it locks in an error state.

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader for the RISC_TOY core.
// Receives a big-endian byte stream of [count N][N words][checksum], writes the
// words to instruction memory at word addresses 0..N-1, then either hands the
// memory port to the core (good checksum) or locks in an error state.
//
// Ports:
//   CLK, RSTN           clock, asynchronous active-low reset
//   RX_VALID/RX_DATA    incoming byte stream; RX_READY accepts a byte
//   IREQ_C/IADDR_C      core instruction fetch request/address (used in RUN only)
//   IM_REQ/IM_WE        instruction-memory request / write enable
//   IM_ADDR/IM_WDATA    instruction-memory word address / write data
//   CORE_RSTN           active-low reset to the core, released after a good load
//   DONE/ERR            image verified / load failed
module imem_loader #(
  parameter int unsigned MAXW = 1024
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        RX_VALID,
  input  logic [7:0]  RX_DATA,
  output logic        RX_READY,
  input  logic        IREQ_C,
  input  logic [29:0] IADDR_C,
  output logic        IM_REQ,
  output logic        IM_WE,
  output logic [29:0] IM_ADDR,
  output logic [31:0] IM_WDATA,
  output logic        CORE_RSTN,
  output logic        DONE,
  output logic        ERR
);

  localparam int unsigned IDXW = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [IDXW-1:0]   n_q, n_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [31:0]       sum_q, sum_d;
  logic              wr_q, wr_d;
  logic [29:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rstn_q, core_rstn_d;

  logic              accept_c;
  logic              word_done_c;
  logic [31:0]       word_c;
  logic [IDXW-1:0]   idx_next_c;

  // Byte assembly, FSM next state, write-pulse generation.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    n_d         = n_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    wr_d        = 1'b0;
    wr_addr_d   = 30'd0;
    wr_data_d   = 32'd0;

    accept_c    = RX_VALID & rx_ready_q;
    word_done_c = accept_c && (byte_cnt_q == 2'd3);
    // The fourth byte completes the word combinationally with the three held bytes.
    word_c      = {shift_q, RX_DATA};
    idx_next_c  = idx_q + IDXW'(1);

    if (accept_c) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], RX_DATA};
    end

    if (word_done_c) begin
      case (state_q)
        S_HDR: begin
          if ((word_c == 32'd0) || (word_c > 32'(MAXW))) begin
            state_d = S_ERROR;
          end else begin
            n_d     = IDXW'(word_c);
            idx_d   = '0;
            sum_d   = 32'd0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          sum_d     = sum_q + word_c;
          wr_d      = 1'b1;
          wr_addr_d = 30'(idx_q);
          wr_data_d = word_c;
          idx_d     = idx_next_c;
          if (idx_next_c == n_q) begin
            state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          state_d = (word_c == sum_q) ? S_RUN : S_ERROR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Status outputs are registered from the next state so they change on the deciding edge.
    rx_ready_d  = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d      = (state_d == S_RUN);
    core_rstn_d = (state_d == S_RUN);
    err_d       = (state_d == S_ERROR);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_HDR;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      n_q         <= '0;
      idx_q       <= '0;
      sum_q       <= 32'd0;
      wr_q        <= 1'b0;
      wr_addr_q   <= 30'd0;
      wr_data_q   <= 32'd0;
      rx_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      wr_q        <= wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rx_ready_q  <= rx_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_rstn_q <= core_rstn_d;
    end
  end

  // In RUN the core owns the memory port directly; otherwise only the write pulse drives it.
  always_comb begin
    if (state_q == S_RUN) begin
      IM_REQ   = IREQ_C;
      IM_WE    = 1'b0;
      IM_ADDR  = IADDR_C;
      IM_WDATA = 32'd0;
    end else begin
      IM_REQ   = wr_q;
      IM_WE    = wr_q;
      IM_ADDR  = wr_addr_q;
      IM_WDATA = wr_data_q;
    end
  end

  assign RX_READY  = rx_ready_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign CORE_RSTN = core_rstn_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Stimulus tasks push the
// expected memory writes into a queue; a monitor pops and compares on every
// write pulse. Status outputs are checked directly after each image.
module tb_imem_loader;

  localparam int unsigned MAXW = 1024;

  logic        CLK;
  logic        RSTN;
  logic        RX_VALID;
  logic [7:0]  RX_DATA;
  logic        RX_READY;
  logic        IREQ_C;
  logic [29:0] IADDR_C;
  logic        IM_REQ;
  logic        IM_WE;
  logic [29:0] IM_ADDR;
  logic [31:0] IM_WDATA;
  logic        CORE_RSTN;
  logic        DONE;
  logic        ERR;

  imem_loader #(.MAXW(MAXW)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .RX_VALID (RX_VALID),
    .RX_DATA  (RX_DATA),
    .RX_READY (RX_READY),
    .IREQ_C   (IREQ_C),
    .IADDR_C  (IADDR_C),
    .IM_REQ   (IM_REQ),
    .IM_WE    (IM_WE),
    .IM_ADDR  (IM_ADDR),
    .IM_WDATA (IM_WDATA),
    .CORE_RSTN(CORE_RSTN),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks;
  int          errors;
  wr_t         exp_q[$];
  logic [31:0] img_q[$];
  logic [29:0] last_addr;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  initial begin
    wr_t e;
    last_addr = 30'd0;
    forever begin
      @(negedge CLK);
      if (IM_WE === 1'b1) begin
        chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(IM_ADDR), 64'(e.addr));
          chk("wr_data", 64'(IM_WDATA), 64'(e.data));
          chk("wr_req", 64'(IM_REQ), 64'd1);
          last_addr = IM_ADDR;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      RX_VALID = 1'b0;
      @(posedge CLK);
      #1;
    end
    RX_VALID = 1'b1;
    RX_DATA  = b;
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], int'($urandom_range(0, gmax)));
    end
  endtask

  task automatic send_image(input logic [31:0] n, input logic [31:0] csum, input int gmax);
    send_word(n, gmax);
    for (int k = 0; k < img_q.size(); k++) begin
      exp_q.push_back({30'(k), img_q[k]});
      send_word(img_q[k], gmax);
    end
    send_word(csum, gmax);
  endtask

  task automatic do_reset();
    RX_VALID = 1'b0;
    IREQ_C   = 1'b0;
    IADDR_C  = 30'd0;
    RSTN     = 1'b0;
    #2;
    chk("reset_outputs",
        64'({RX_READY, IM_REQ, IM_WE, IM_ADDR, IM_WDATA, CORE_RSTN, DONE, ERR}),
        64'({1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b0}));
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 64'(DONE), 64'd1);
    chk({tag, "_core_rstn"}, 64'(CORE_RSTN), 64'd1);
    chk({tag, "_err"}, 64'(ERR), 64'd0);
    chk({tag, "_rx_ready"}, 64'(RX_READY), 64'd0);
    chk({tag, "_wr_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_basic_image();
    img_q.delete();
    img_q.push_back(32'h0840_0001);
    img_q.push_back(32'h0000_0010);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RSTN     = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'd0;
    IREQ_C   = 1'b0;
    IADDR_C  = 30'd0;
    #12;

    // Good image, back-to-back, then core pass-through.
    do_reset();
    load_basic_image();
    send_image(32'd2, 32'h0840_0011, 0);
    check_done("good");
    IADDR_C = 30'h5;
    IREQ_C  = 1'b1;
    #1;
    chk("pt_addr", 64'(IM_ADDR), 64'h5);
    chk("pt_req", 64'(IM_REQ), 64'd1);
    chk("pt_we", 64'(IM_WE), 64'd0);
    chk("pt_wdata", 64'(IM_WDATA), 64'd0);
    IREQ_C  = 1'b0;
    IADDR_C = 30'h3FFF_FFFF;
    #1;
    chk("pt_req_low", 64'(IM_REQ), 64'd0);
    chk("pt_addr_max", 64'(IM_ADDR), 64'h3FFF_FFFF);

    // Bad checksum locks in ERROR; later bytes and core requests are ignored.
    do_reset();
    load_basic_image();
    send_image(32'd2, 32'h0840_0012, 0);
    chk("bad_err", 64'(ERR), 64'd1);
    chk("bad_core_rstn", 64'(CORE_RSTN), 64'd0);
    chk("bad_done", 64'(DONE), 64'd0);
    chk("bad_rx_ready", 64'(RX_READY), 64'd0);
    IREQ_C  = 1'b1;
    IADDR_C = 30'h7;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'hA0 + i), 0);
      chk("bad_im_req", 64'(IM_REQ), 64'd0);
    end
    chk("bad_err_hold", 64'(ERR), 64'd1);
    chk("bad_wr_drained", 64'(exp_q.size()), 64'd0);

    // Header N=0.
    do_reset();
    send_word(32'd0, 0);
    chk("n0_err", 64'(ERR), 64'd1);
    chk("n0_rx_ready", 64'(RX_READY), 64'd0);
    chk("n0_im_we", 64'(IM_WE), 64'd0);

    // Header N=MAXW+1.
    do_reset();
    send_word(32'(MAXW + 1), 0);
    chk("nmax1_err", 64'(ERR), 64'd1);
    chk("nmax1_done", 64'(DONE), 64'd0);

    // Header N=MAXW with words 0..1023: checksum 1023*1024/2 = 0x7FE00.
    do_reset();
    img_q.delete();
    for (int k = 0; k < int'(MAXW); k++) img_q.push_back(32'(k));
    send_image(32'(MAXW), 32'h0007_FE00, 0);
    check_done("nmax");
    chk("nmax_last_addr", 64'(last_addr), 64'(MAXW - 1));

    // Throttled stream with random gaps.
    do_reset();
    load_basic_image();
    send_image(32'd2, 32'h0840_0011, 5);
    check_done("throttle");

    // Reset after header plus six data bytes, then a full reload.
    do_reset();
    send_word(32'd2, 0);
    exp_q.push_back({30'd0, 32'h0840_0001});
    send_word(32'h0840_0001, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("midrst_wr0_seen", 64'(exp_q.size()), 64'd0);
    do_reset();
    load_basic_image();
    send_image(32'd2, 32'h0840_0011, 0);
    check_done("midrst");

    // Sum wraps modulo 2^32.
    do_reset();
    img_q.delete();
    img_q.push_back(32'hFFFF_FFFF);
    img_q.push_back(32'h0000_0002);
    send_image(32'd2, 32'h0000_0001, 0);
    check_done("wrap");

    repeat (2) @(posedge CLK);
    chk("final_wr_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
